store_drain_queue: RTL and testbench

STORE_DRAIN_QUEUE -- requirements
Module: store_drain_queue

---
 rtl/store_drain_queue.sv | 167 ++++++++++++++++
 tb/tb_store_drain_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_queue.sv
// store_drain_queue: in-order store queue with out-of-order fill, commit/flush
// bookkeeping and a single-outstanding request/ack drain port to memory.
module store_drain_queue #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alloc,
    output logic [WIDTH-1:0] o_alloc_tag,
    output logic             o_full,
    output logic             o_empty,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_addr,
    input  logic [31:0]      i_wr_data,
    input  logic [3:0]       i_wr_mask,
    input  logic             i_commit,
    input  logic             i_flush,
    output logic             o_mem_req,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_data,
    output logic [3:0]       o_mem_mask,
    input  logic             i_mem_ack
);

    localparam int unsigned SIZE = 2 ** WIDTH;
    localparam int unsigned PW   = WIDTH + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } store_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // Pointers carry a wrap bit above the entry index
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   cmt_q,  cmt_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [SIZE-1:0] filled_q, filled_d;
    store_t          entry_q [SIZE];

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    store_t          req_q, req_d;

    logic [WIDTH-1:0] head_idx, cmt_idx, tail_idx;
    logic [WIDTH-1:0] off_head, off_cmt;
    logic [PW-1:0]    used_cnt, uncmt_cnt;
    logic             full_c, empty_c;
    logic             tag_alloc_c, tag_uncmt_c;
    logic             wr_ok_c, alloc_ok_c, commit_ok_c, head_adv_c;
    store_t           wr_entry_c;

    assign head_idx  = head_q[WIDTH-1:0];
    assign cmt_idx   = cmt_q[WIDTH-1:0];
    assign tail_idx  = tail_q[WIDTH-1:0];
    assign used_cnt  = tail_q - head_q;
    assign uncmt_cnt = tail_q - cmt_q;

    // Occupancy from registered pointers only
    assign full_c  = (used_cnt == PW'(SIZE));
    assign empty_c = (tail_q == head_q);

    // Distance of the write tag from head/cmt decides whether it is allocated
    assign off_head    = i_wr_tag - head_idx;
    assign off_cmt     = i_wr_tag - cmt_idx;
    assign tag_alloc_c = ({1'b0, off_head} < used_cnt);
    assign tag_uncmt_c = ({1'b0, off_cmt} < uncmt_cnt);

    // Committed entries may be written only until they are filled once
    assign wr_ok_c     = i_wr_en && (tag_uncmt_c || (tag_alloc_c && !filled_q[i_wr_tag]));
    assign alloc_ok_c  = i_alloc && !full_c && !i_flush;
    assign commit_ok_c = i_commit && (cmt_q != tail_q);
    assign head_adv_c  = (state_q == REQ) && i_mem_ack;

    assign wr_entry_c = '{addr: i_wr_addr, data: i_wr_data, mask: i_wr_mask};

    // Pointer and filled-bit next state; alloc clears after a write so it wins
    always_comb begin
        head_d   = head_q;
        cmt_d    = cmt_q;
        tail_d   = tail_q;
        filled_d = filled_q;
        if (wr_ok_c) begin
            filled_d[i_wr_tag] = 1'b1;
        end
        if (alloc_ok_c) begin
            filled_d[tail_idx] = 1'b0;
            tail_d             = tail_q + PW'(1);
        end
        if (commit_ok_c) begin
            cmt_d = cmt_q + PW'(1);
        end
        if (i_flush) begin
            tail_d = cmt_d;
        end
        if (head_adv_c) begin
            head_d = head_q + PW'(1);
        end
    end

    // Drain FSM: launch from registered head state, hold payload until ack
    always_comb begin
        state_d   = state_q;
        mem_req_d = 1'b0;
        req_d     = '0;
        case (state_q)
            IDLE: begin
                if ((head_q != cmt_q) && filled_q[head_idx]) begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    req_d     = entry_q[head_idx];
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    state_d = IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    req_d     = req_q;
                end
            end
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            filled_q  <= '0;
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            req_q     <= '0;
        end else begin
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            filled_q  <= filled_d;
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            req_q     <= req_d;
        end
    end

    // Entry payload storage; validity is tracked by filled_q
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_ok_c) begin
            entry_q[i_wr_tag] <= wr_entry_c;
        end
    end

    assign o_alloc_tag = tail_idx;
    assign o_full      = full_c;
    assign o_empty     = empty_c;
    assign o_mem_req   = mem_req_q;
    assign o_mem_addr  = req_q.addr;
    assign o_mem_data  = req_q.data;
    assign o_mem_mask  = req_q.mask;

endmodule

// File: tb/tb_store_drain_queue.sv
// tb_store_drain_queue: directed scenarios plus random traffic against a
// sequence-number reference model of the store queue.
module tb_store_drain_queue;

    localparam int unsigned W    = 2;
    localparam int          SIZE = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_alloc = 1'b0;
    logic [W-1:0]  o_alloc_tag;
    logic          o_full, o_empty;
    logic          i_wr_en = 1'b0;
    logic [W-1:0]  i_wr_tag = '0;
    logic [31:0]   i_wr_addr = '0, i_wr_data = '0;
    logic [3:0]    i_wr_mask = '0;
    logic          i_commit = 1'b0, i_flush = 1'b0;
    logic          o_mem_req;
    logic [31:0]   o_mem_addr, o_mem_data;
    logic [3:0]    o_mem_mask;
    logic          i_mem_ack = 1'b0;

    store_drain_queue #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_alloc(i_alloc), .o_alloc_tag(o_alloc_tag),
        .o_full(o_full), .o_empty(o_empty), .i_wr_en(i_wr_en), .i_wr_tag(i_wr_tag),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_mask(i_wr_mask),
        .i_commit(i_commit), .i_flush(i_flush), .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_mask(o_mem_mask),
        .i_mem_ack(i_mem_ack)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Drive values for the next edge
    bit          d_rst, d_alloc, d_wr, d_commit, d_flush, d_ack;
    int          d_tag;
    logic [31:0] d_addr, d_data;
    logic [3:0]  d_mask;

    // Reference model: unbounded sequence numbers for head/commit/tail
    int          m_head, m_cmt, m_tail;
    bit          m_req;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_mask;
    logic [31:0] e_addr [SIZE];
    logic [31:0] e_data [SIZE];
    logic [3:0]  e_mask [SIZE];
    bit          e_filled [SIZE];

    logic [31:0] issued_addr [$];
    int          issued_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int oh, cnt, off, s, n_cmt, n_tail;
        bit full;
        if (d_rst) begin
            m_head = 0; m_cmt = 0; m_tail = 0; m_req = 0;
            m_addr = '0; m_data = '0; m_mask = '0;
            foreach (e_filled[i]) e_filled[i] = 0;
            return;
        end
        oh   = m_head;
        cnt  = m_tail - m_head;
        full = (cnt == SIZE);
        // drain port, judged on state before this edge
        if (m_req) begin
            if (d_ack) begin
                m_req = 0; m_head++;
                m_addr = '0; m_data = '0; m_mask = '0;
            end
        end else if (m_head != m_cmt && e_filled[m_head % SIZE]) begin
            m_req  = 1;
            m_addr = e_addr[m_head % SIZE];
            m_data = e_data[m_head % SIZE];
            m_mask = e_mask[m_head % SIZE];
        end
        // fill: allocated, and either uncommitted or committed-but-empty
        off = (d_tag - (oh % SIZE) + SIZE) % SIZE;
        if (d_wr && off < cnt) begin
            s = oh + off;
            if (s >= m_cmt || !e_filled[d_tag]) begin
                e_addr[d_tag] = d_addr; e_data[d_tag] = d_data; e_mask[d_tag] = d_mask;
                e_filled[d_tag] = 1;
            end
        end
        n_cmt = m_cmt; n_tail = m_tail;
        if (d_alloc && !full && !d_flush) begin
            e_filled[m_tail % SIZE] = 0;
            n_tail++;
        end
        if (d_commit && m_cmt != m_tail) n_cmt++;
        if (d_flush) n_tail = n_cmt;
        m_cmt = n_cmt; m_tail = n_tail;
    endtask

    task automatic tick();
        i_rst = d_rst; i_alloc = d_alloc; i_wr_en = d_wr; i_wr_tag = W'(d_tag);
        i_wr_addr = d_addr; i_wr_data = d_data; i_wr_mask = d_mask;
        i_commit = d_commit; i_flush = d_flush; i_mem_ack = d_ack;
        if (d_ack && o_mem_req === 1'b1 && !d_rst) begin
            issued_addr.push_back(o_mem_addr);
            issued_cyc.push_back(cyc);
        end
        @(posedge i_clk);
        model_edge();
        cyc++;
        @(negedge i_clk);
        chk("mem_req",   32'(o_mem_req),   32'(m_req));
        chk("mem_addr",  o_mem_addr,       m_addr);
        chk("mem_data",  o_mem_data,       m_data);
        chk("mem_mask",  32'(o_mem_mask),  32'(m_mask));
        chk("full",      32'(o_full),      32'(m_tail - m_head == SIZE));
        chk("empty",     32'(o_empty),     32'(m_tail == m_head));
        chk("alloc_tag", 32'(o_alloc_tag), 32'(m_tail % SIZE));
        d_rst = 0; d_alloc = 0; d_wr = 0; d_commit = 0; d_flush = 0; d_ack = 0;
        d_tag = 0; d_addr = '0; d_data = '0; d_mask = '0;
    endtask

    task automatic do_reset();
        d_rst = 1; tick();
    endtask

    task automatic do_alloc();
        d_alloc = 1; tick();
    endtask

    task automatic do_commit();
        d_commit = 1; tick();
    endtask

    task automatic do_write(input int tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        d_wr = 1; d_tag = tag; d_addr = a; d_data = d; d_mask = m; tick();
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            d_ack = 1; tick();
        end
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (o_mem_req !== 1'b1 && k < 10) begin
            tick(); k++;
        end
        chk(tag, 32'(o_mem_req), 32'd1);
    endtask

    initial begin
        int t0, t1;
        logic [31:0] ra;

        // reset state
        do_reset();
        chk("rst_req",   32'(o_mem_req),   32'd0);
        chk("rst_empty", 32'(o_empty),     32'd1);
        chk("rst_full",  32'(o_full),      32'd0);
        chk("rst_tag",   32'(o_alloc_tag), 32'd0);
        chk("rst_addr",  o_mem_addr,       32'd0);

        // simple drain, request two edges after commit
        do_alloc();
        do_write(0, 32'h100, 32'hDEADBEEF, 4'hF);
        do_commit();
        chk("s1_req_early", 32'(o_mem_req), 32'd0);
        tick();
        chk("s1_req",  32'(o_mem_req),  32'd1);
        chk("s1_addr", o_mem_addr,      32'h100);
        chk("s1_data", o_mem_data,      32'hDEADBEEF);
        chk("s1_mask", 32'(o_mem_mask), 32'hF);
        d_ack = 1; tick();
        chk("s1_empty", 32'(o_empty),   32'd1);
        chk("s1_done",  32'(o_mem_req), 32'd0);

        // out-of-order fill, in-order drain with an idle gap
        t0 = int'(o_alloc_tag); do_alloc();
        t1 = int'(o_alloc_tag); do_alloc();
        do_write(t1, 32'h200, 32'h2222, 4'h3);
        do_write(t0, 32'h300, 32'h3333, 4'hC);
        issued_addr.delete(); issued_cyc.delete();
        do_commit();
        do_commit();
        drain(8);
        chk("s2_count", 32'(issued_addr.size()), 32'd2);
        if (issued_addr.size() == 2) begin
            chk("s2_first",  issued_addr[0], 32'h300);
            chk("s2_second", issued_addr[1], 32'h200);
            chk("s2_gap",    32'(issued_cyc[1] - issued_cyc[0]), 32'd2);
        end

        // full and wrap
        do_reset();
        repeat (4) do_alloc();
        chk("s3_full", 32'(o_full), 32'd1);
        do_alloc();
        chk("s3_full_hold", 32'(o_full),      32'd1);
        chk("s3_tag_hold",  32'(o_alloc_tag), 32'd0);
        do_write(0, 32'h10, 32'h1, 4'h1);
        do_write(1, 32'h14, 32'h2, 4'h2);
        do_commit(); do_commit();
        issued_addr.delete(); issued_cyc.delete();
        drain(6);
        chk("s3_drained", 32'(issued_addr.size()), 32'd2);
        chk("s3_wrap0",   32'(o_alloc_tag), 32'd0);
        do_alloc();
        chk("s3_wrap1",   32'(o_alloc_tag), 32'd1);
        do_alloc();
        chk("s3_refull",  32'(o_full),      32'd1);
        chk("s3_tag2",    32'(o_alloc_tag), 32'd2);
        // alloc together with ack while full is rejected
        do_write(2, 32'h18, 32'h3, 4'h4);
        do_commit();
        wait_req("s3_req");
        d_alloc = 1; d_ack = 1; tick();
        chk("s3_ack_full", 32'(o_full),      32'd0);
        chk("s3_ack_tag",  32'(o_alloc_tag), 32'd2);

        // flush together with commit keeps the newly committed entry
        do_reset();
        repeat (3) do_alloc();
        do_commit();
        d_flush = 1; d_commit = 1; tick();
        chk("s4_tail", 32'(o_alloc_tag), 32'd2);
        issued_addr.delete(); issued_cyc.delete();
        do_write(0, 32'h40, 32'h4, 4'h1);
        do_write(1, 32'h44, 32'h5, 4'h2);
        do_write(2, 32'h48, 32'h6, 4'h3);
        drain(10);
        chk("s4_count", 32'(issued_addr.size()), 32'd2);
        if (issued_addr.size() == 2) begin
            chk("s4_first",  issued_addr[0], 32'h40);
            chk("s4_second", issued_addr[1], 32'h44);
        end
        chk("s4_empty", 32'(o_empty), 32'd1);
        d_alloc = 1; d_flush = 1; tick();
        chk("s4_alloc_drop", 32'(o_alloc_tag), 32'd2);

        // backpressure holds the request stable
        do_reset();
        do_alloc();
        do_write(0, 32'hA5A5_0000, 32'h1234_5678, 4'h9);
        do_commit();
        wait_req("s5_req");
        repeat (10) begin
            tick();
            chk("s5_hold_req",  32'(o_mem_req),  32'd1);
            chk("s5_hold_addr", o_mem_addr,      32'hA5A5_0000);
            chk("s5_hold_data", o_mem_data,      32'h1234_5678);
            chk("s5_hold_mask", 32'(o_mem_mask), 32'h9);
        end
        d_ack = 1; tick();
        chk("s5_adv", 32'(o_empty), 32'd1);

        // reset abandons a pending request
        do_alloc();
        do_write(1, 32'hBEEF, 32'h77, 4'hF);
        do_commit();
        wait_req("s6_req");
        do_reset();
        chk("s6_req",   32'(o_mem_req), 32'd0);
        chk("s6_empty", 32'(o_empty),   32'd1);
        d_ack = 1; tick();
        chk("s6_ack_ign", 32'(o_mem_req),   32'd0);
        chk("s6_tag",     32'(o_alloc_tag), 32'd0);

        // random traffic against the model
        ra = '0;
        for (int n = 0; n < 3000; n++) begin
            d_rst    = ($urandom_range(0, 199) == 0);
            d_alloc  = ($urandom_range(0, 1) == 1);
            d_wr     = ($urandom_range(0, 9) < 6);
            d_tag    = int'($urandom_range(0, SIZE - 1));
            ra       = $urandom;
            d_addr   = ra;
            d_data   = $urandom;
            d_mask   = 4'($urandom);
            d_commit = ($urandom_range(0, 9) < 4);
            d_flush  = ($urandom_range(0, 19) == 0);
            d_ack    = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
